demux_1x8_deser: RTL and testbench

Sequential 1:8 demultiplexer/deserializer: the receive end of an 8:1 mux-based serial link. It accepts one bit per qualified cycle, steers it into output lane `s` (slot index 0..7), and presents the reassembled 8-bit word with a one-cycle valid pulse. It sits downstream of the 8:1 mux serializer path and restores the parallel `i[7:0]` vector that the mux time-multiplexed onto a single line.

---
 rtl/demux_1x8_deser.sv | 127 ++++++++++++
 tb/tb_demux_1x8_deser.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x8_deser.sv
// Receive end of an 8:1 serial link: steers qualified bits into lanes and emits the rebuilt word with a valid pulse.
// Define DEMUX_1X8_PARITY_EN to add a trailing even-parity slot (9-bit frames, 4-bit sel, parity_err output).
module demux_1x8_deser #(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    input  logic       sync,
    output logic [7:0] dout,
    output logic       dout_valid,
`ifdef DEMUX_1X8_PARITY_EN
    output logic [3:0] sel,
    output logic       frame_err,
    output logic       parity_err
`else
    output logic [2:0] sel,
    output logic       frame_err
`endif
);

`ifdef DEMUX_1X8_PARITY_EN
    localparam int            SW        = 4;
    localparam logic [SW-1:0] LAST_SLOT = 4'd8;
`else
    localparam int            SW        = 3;
    localparam logic [SW-1:0] LAST_SLOT = 3'd7;
`endif

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t        state, next_state;
    logic [7:0]    stage, next_stage;
    logic [7:0]    next_dout;
    logic [SW-1:0] next_sel;
    logic          next_dout_valid;
    logic          next_frame_err;
`ifdef DEMUX_1X8_PARITY_EN
    logic          next_parity_err;
`endif

    // Slot-to-lane mapping: slot s lands in bit s, or bit 7-s when MSB-first.
    function automatic logic [7:0] put_bit(input logic [7:0] word, input logic [2:0] slot,
                                           input logic b);
        logic [7:0] w;
        logic [2:0] idx;
        w        = word;
        idx      = (LSB_FIRST != 0) ? slot : 3'd7 - slot;
        w[idx]   = b;
        return w;
    endfunction

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        next_state      = state;
        next_stage      = stage;
        next_sel        = sel;
        next_dout       = dout;
        next_dout_valid = 1'b0;
        next_frame_err  = 1'b0;
`ifdef DEMUX_1X8_PARITY_EN
        next_parity_err = 1'b0;
`endif
        if (din_valid) begin
            if (state == IDLE) begin
                if (sync) begin
                    next_stage = put_bit(8'h00, 3'd0, din);
                    next_sel   = SW'(1);
                    next_state = COLLECT;
                end
            end else if (sync && sel != '0) begin
                // Early frame start: drop the partial word, this bit opens a new frame.
                next_frame_err = 1'b1;
                next_stage     = put_bit(8'h00, 3'd0, din);
                next_sel       = SW'(1);
            end else if (sel == LAST_SLOT) begin
                next_sel   = '0;
                next_stage = 8'h00;
`ifdef DEMUX_1X8_PARITY_EN
                // Even parity: the parity bit equals the XOR of the eight data slots.
                if ((^stage) == din) begin
                    next_dout       = stage;
                    next_dout_valid = 1'b1;
                end else begin
                    next_parity_err = 1'b1;
                end
`else
                next_dout       = put_bit(stage, 3'd7, din);
                next_dout_valid = 1'b1;
`endif
            end else begin
                next_stage = put_bit(stage, sel[2:0], din);
                next_sel   = sel + SW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            stage      <= 8'h00;
            sel        <= '0;
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef DEMUX_1X8_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= next_state;
            stage      <= next_stage;
            sel        <= next_sel;
            dout       <= next_dout;
            dout_valid <= next_dout_valid;
            frame_err  <= next_frame_err;
`ifdef DEMUX_1X8_PARITY_EN
            parity_err <= next_parity_err;
`endif
        end
    end

endmodule

// File: tb/tb_demux_1x8_deser.sv
// Self-checking bench for demux_1x8_deser: directed scenarios plus random traffic against a queue-based frame model.
// Builds with or without DEMUX_1X8_PARITY_EN; parity scenarios run only when it is defined.
module tb_demux_1x8_deser;

`ifdef DEMUX_1X8_PARITY_EN
    localparam int NSLOT = 9;
    localparam int SW    = 4;
`else
    localparam int NSLOT = 8;
    localparam int SW    = 3;
`endif
    localparam int LSB = 1;

    logic          clk = 1'b0;
    logic          rst, din, din_valid, sync;
    logic [7:0]    dout;
    logic          dout_valid, frame_err, pe_obs;
    logic [SW-1:0] sel;

    demux_1x8_deser #(.LSB_FIRST(LSB)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
`ifdef DEMUX_1X8_PARITY_EN
        .sel        (sel),
        .frame_err  (frame_err),
        .parity_err (pe_obs)
`else
        .sel        (sel),
        .frame_err  (frame_err)
`endif
    );

`ifndef DEMUX_1X8_PARITY_EN
    assign pe_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    wire [SW+10:0] obs = {dout, dout_valid, frame_err, pe_obs, sel};

    // Reference model: the bits of the current frame, in arrival order.
    bit            q[$];
    bit            m_active;
    logic [7:0]    exp_dout;
    logic          exp_dv, exp_fe, exp_pe;
    logic [SW-1:0] exp_sel;

    function automatic logic [SW+10:0] exp_vec();
        return {exp_dout, exp_dv, exp_fe, exp_pe, exp_sel};
    endfunction

    task automatic model_reset();
        q.delete();
        m_active = 1'b0;
        exp_dout = 8'h00;
        exp_dv   = 1'b0;
        exp_fe   = 1'b0;
        exp_pe   = 1'b0;
        exp_sel  = '0;
    endtask

    task automatic model_step(input logic d, input logic v, input logic s);
        logic [7:0] w;
        int         ones;
        exp_dv = 1'b0;
        exp_fe = 1'b0;
        exp_pe = 1'b0;
        if (v) begin
            if (!m_active) begin
                if (s) begin
                    m_active = 1'b1;
                    q.delete();
                    q.push_back(d);
                end
            end else if (s && q.size() != 0) begin
                exp_fe = 1'b1;
                q.delete();
                q.push_back(d);
            end else begin
                q.push_back(d);
                if (q.size() == NSLOT) begin
                    w    = 8'h00;
                    ones = 0;
                    for (int i = 0; i < NSLOT; i++) begin
                        if (i < 8) w[(LSB != 0) ? i : 7 - i] = q[i];
                        ones += int'(q[i]);
                    end
                    if (NSLOT == 8 || ones % 2 == 0) begin
                        exp_dout = w;
                        exp_dv   = 1'b1;
                    end else begin
                        exp_pe = 1'b1;
                    end
                    q.delete();
                end
            end
        end
        exp_sel = SW'(q.size());
    endtask

    // Bit carried by slot s of word w; slot 8 (parity builds only) is the even-parity bit.
    function automatic logic slot_bit(input logic [7:0] w, input int s);
        if (s < 8) return w[(LSB != 0) ? s : 7 - s];
        return ^w;
    endfunction

    task automatic drive(input logic d, input logic v, input logic s);
        din       = d;
        din_valid = v;
        sync      = s;
        model_step(d, v, s);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", dout);
        else n_pass++;
        n_checks++;
        if ({dout_valid, frame_err, pe_obs, sel} !== '0)
            $display("FAIL reset_flags: got dv=%b fe=%b pe=%b sel=%0d want all 0", dout_valid, frame_err, pe_obs, sel);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom), 1'b1, 1'b0);
            n_checks++;
            if ({dout, dout_valid, frame_err, pe_obs, sel} !== '0)
                $display("FAIL idle_quiet: got dout=%h dv=%b fe=%b sel=%0d want all 0", dout, dout_valid, frame_err, sel);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        for (int s = 0; s < NSLOT; s++) begin
            drive(slot_bit(8'h4D, s), 1'b1, s == 0);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL basic_step%0d: got %h want %h", s, obs, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (dout !== 8'h4D || dout_valid !== 1'b1 || sel !== '0)
            $display("FAIL basic_word: got dout=%h dv=%b sel=%0d want 4d 1 0", dout, dout_valid, sel);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dout_valid !== 1'b0 || dout !== 8'h4D)
            $display("FAIL basic_pulse_width: got dv=%b dout=%h want 0 4d", dout_valid, dout);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int         pulses = 0;
        int         pcyc[2];
        logic [7:0] pword[2];
        logic [7:0] w;
        for (int f = 0; f < 2; f++) begin
            w = (f == 0) ? 8'hA5 : 8'h3C;
            for (int s = 0; s < NSLOT; s++) begin
                drive(slot_bit(w, s), 1'b1, (f == 0) && (s == 0));
                n_checks++;
                if (obs !== exp_vec()) $display("FAIL b2b_step%0d_%0d: got %h want %h", f, s, obs, exp_vec());
                else n_pass++;
                if (dout_valid === 1'b1) begin
                    if (pulses < 2) begin
                        pcyc[pulses]  = cyc;
                        pword[pulses] = dout;
                    end
                    pulses++;
                end
            end
        end
        n_checks++;
        if (pulses != 2) $display("FAIL b2b_pulses: got %0d want 2", pulses);
        else begin
            n_pass++;
            n_checks++;
            if (pcyc[1] - pcyc[0] != NSLOT) $display("FAIL b2b_spacing: got %0d want %0d", pcyc[1] - pcyc[0], NSLOT);
            else n_pass++;
            n_checks++;
            if (pword[0] !== 8'hA5 || pword[1] !== 8'h3C)
                $display("FAIL b2b_words: got %h %h want a5 3c", pword[0], pword[1]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        int c0 = 0;
        int cdv = -1;
        for (int s = 0; s < NSLOT; s++) begin
            if (s == 4) begin
                for (int k = 0; k < 3; k++) begin
                    drive(1'($urandom), 1'b0, 1'($urandom));
                    n_checks++;
                    if (sel !== SW'(4) || dout_valid !== 1'b0)
                        $display("FAIL stall_hold%0d: got sel=%0d dv=%b want 4 0", k, sel, dout_valid);
                    else n_pass++;
                end
            end
            drive(slot_bit(8'hF0, s), 1'b1, s == 0);
            if (s == 0) c0 = cyc;
            if (dout_valid === 1'b1) cdv = cyc;
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL stall_step%0d: got %h want %h", s, obs, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (dout !== 8'hF0 || cdv - c0 != NSLOT + 2)
            $display("FAIL stall_word: got dout=%h delay=%0d want f0 %0d", dout, cdv - c0, NSLOT + 2);
        else n_pass++;
    endtask

    task automatic test_early_sync();
        for (int s = 0; s < 5; s++) drive(slot_bit(8'h5A, s), 1'b1, s == 0);
        n_checks++;
        if (sel !== SW'(5)) $display("FAIL early_pre_sel: got %0d want 5", sel);
        else n_pass++;
        drive(slot_bit(8'h81, 0), 1'b1, 1'b1);
        n_checks++;
        if (frame_err !== 1'b1 || dout_valid !== 1'b0 || dout !== 8'hF0 || sel !== SW'(1))
            $display("FAIL early_abort: got fe=%b dv=%b dout=%h sel=%0d want 1 0 f0 1", frame_err, dout_valid, dout, sel);
        else n_pass++;
        for (int s = 1; s < NSLOT; s++) begin
            drive(slot_bit(8'h81, s), 1'b1, 1'b0);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL early_step%0d: got %h want %h", s, obs, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (dout !== 8'h81 || dout_valid !== 1'b1 || frame_err !== 1'b0)
            $display("FAIL early_word: got dout=%h dv=%b fe=%b want 81 1 0", dout, dout_valid, frame_err);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        for (int s = 0; s < 6; s++) drive(1'($urandom), 1'b1, s == 0);
        n_checks++;
        if (sel !== SW'(6)) $display("FAIL midrst_pre_sel: got %0d want 6", sel);
        else n_pass++;
        rst = 1'b1;
        #2;
        n_checks++;
        if (sel !== '0 || dout !== 8'h00 || dout_valid !== 1'b0)
            $display("FAIL midrst_async: got sel=%0d dout=%h dv=%b want 0 00 0", sel, dout, dout_valid);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (sel !== '0 || dout !== 8'h00) $display("FAIL midrst_idle: got sel=%0d dout=%h want 0 00", sel, dout);
        else n_pass++;
    endtask

    task automatic test_random();
        logic v, s;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 11) == 0);
            drive(1'($urandom), v, s);
            n_checks++;
            if (obs !== exp_vec() || (dout_valid && frame_err))
                $display("FAIL random_cyc%0d: got %h want %h", i, obs, exp_vec());
            else n_pass++;
        end
    endtask

`ifdef DEMUX_1X8_PARITY_EN
    task automatic test_parity();
        for (int s = 0; s < NSLOT; s++) drive(slot_bit(8'h4D, s), 1'b1, s == 0);
        n_checks++;
        if (dout !== 8'h4D || dout_valid !== 1'b1 || pe_obs !== 1'b0)
            $display("FAIL parity_good: got dout=%h dv=%b pe=%b want 4d 1 0", dout, dout_valid, pe_obs);
        else n_pass++;
        for (int s = 0; s < NSLOT; s++) drive((s < 8) ? slot_bit(8'h12, s) : 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (dout !== 8'h4D || dout_valid !== 1'b0 || pe_obs !== 1'b1)
            $display("FAIL parity_bad: got dout=%h dv=%b pe=%b want 4d 0 1", dout, dout_valid, pe_obs);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (pe_obs !== 1'b0) $display("FAIL parity_pulse_width: got %b want 0", pe_obs);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_back_to_back();
        test_stall();
        test_early_sync();
        test_mid_reset();
`ifdef DEMUX_1X8_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
